hll_touch_dispatcher: RTL and testbench

- Initiator side of the HLL cell touch interface. Accepts a stream of hash words and converts each one into a single-lane connection request (touch) aimed at one of NUM_CELLS HLL cells.
- Cell index and lane index come from the hash low bits. Touches to cells that are already active are suppressed.
- Sits between the hash front-end and the HLL cell array. touch_attempts is fanned out to the selected cell's touch input.

---
 rtl/hll_touch_dispatcher.sv | 151 +++++++++++++++
 tb/tb_hll_touch_dispatcher.sv | 216 +++++++++++++++++++++
 2 files changed

// File: rtl/hll_touch_dispatcher.sv
// hll_touch_dispatcher: initiator side of the HLL cell touch interface.
// Buffers incoming hash words, splits each into a cell index (low CW bits)
// and a lane index (next LW bits), and drives a one-hot single-lane touch
// toward that cell unless the cell is already active.
// Optional macro HLL_TOUCH_DEDUP_EN: drop a hash whose {cell,lane} matches
// the most recently issued touch.
module hll_touch_dispatcher #(
  parameter int HASH_WIDTH  = 64,
  parameter int IN_DEGREE   = 256,
  parameter int NUM_CELLS   = 16,
  parameter int FIFO_DEPTH  = 4,
  parameter int HOLD_CYCLES = 1
) (
  input  logic                          clk,
  input  logic                          reset_n,
  input  logic                          hash_valid,
  output logic                          hash_ready,
  input  logic [HASH_WIDTH-1:0]         hash_data,
  input  logic [NUM_CELLS-1:0]          cell_active,
  output logic                          touch_valid,
  output logic [$clog2(NUM_CELLS)-1:0]  touch_cell,
  output logic [IN_DEGREE-1:0]          touch_attempts,
  output logic                          busy,
  output logic [15:0]                   dropped_count
);

  localparam int LW = $clog2(IN_DEGREE);
  localparam int CW = $clog2(NUM_CELLS);
  localparam int KW = CW + LW;
  localparam int AW = $clog2(FIFO_DEPTH);

  typedef enum logic [1:0] {IDLE, DECODE, ISSUE, GAP} state_t;

  state_t        state;
  logic [KW-1:0] mem [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [AW:0]   count;
  logic          push;
  logic          pop;
  logic          full;
  logic          empty;
  logic [KW-1:0] hash_reg;
  logic [3:0]    hold_cnt;
  logic [CW-1:0] dec_cell;
  logic [LW-1:0] dec_lane;
  logic          dec_dup;
  logic          dec_drop;
  logic          unused_hash_bits;

  // Only the cell and lane fields are ever used; the rest of the hash is ignored.
  assign unused_hash_bits = ^hash_data[HASH_WIDTH-1:KW];

  assign full       = (count == (AW+1)'(FIFO_DEPTH));
  assign empty      = (count == '0);
  assign hash_ready = !full;
  assign push       = hash_valid && !full;
  assign pop        = (state == IDLE) && !empty;
  assign busy       = (state != IDLE) || !empty;

  assign dec_cell = hash_reg[CW-1:0];
  assign dec_lane = hash_reg[KW-1:CW];

`ifdef HLL_TOUCH_DEDUP_EN
  logic [KW-1:0] last_pair;
  logic          last_valid;
  assign dec_dup = last_valid && (last_pair == hash_reg);
`else
  assign dec_dup = 1'b0;
`endif

  assign dec_drop = cell_active[dec_cell] || dec_dup;

  // FIFO storage: write the cell/lane field of each accepted hash.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= hash_data[KW-1:0];
  end

  // FIFO pointers and occupancy; pointers wrap naturally at the power-of-2 depth.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // Touch FSM: pop, decode/suppress, hold the touch, then force a gap cycle.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state          <= IDLE;
      hash_reg       <= '0;
      hold_cnt       <= '0;
      touch_valid    <= 1'b0;
      touch_cell     <= '0;
      touch_attempts <= '0;
      dropped_count  <= '0;
`ifdef HLL_TOUCH_DEDUP_EN
      last_pair      <= '0;
      last_valid     <= 1'b0;
`endif
    end else begin
      case (state)
        IDLE: begin
          if (!empty) begin
            hash_reg <= mem[rd_ptr];
            state    <= DECODE;
          end
        end
        DECODE: begin
          if (dec_drop) begin
            if (dropped_count != 16'hFFFF) dropped_count <= dropped_count + 16'd1;
            state <= IDLE;
          end else begin
            touch_valid    <= 1'b1;
            touch_cell     <= dec_cell;
            touch_attempts <= {{(IN_DEGREE-1){1'b0}}, 1'b1} << dec_lane;
            hold_cnt       <= 4'(HOLD_CYCLES - 1);
            state          <= ISSUE;
`ifdef HLL_TOUCH_DEDUP_EN
            last_pair      <= hash_reg;
            last_valid     <= 1'b1;
`endif
          end
        end
        ISSUE: begin
          if (hold_cnt == 4'd0) begin
            touch_valid    <= 1'b0;
            touch_attempts <= '0;
            state          <= GAP;
          end else begin
            hold_cnt <= hold_cnt - 4'd1;
          end
        end
        GAP: begin
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_hll_touch_dispatcher.sv
// Directed self-checking bench for hll_touch_dispatcher (default parameters).
// Inputs are driven and outputs sampled on the falling clock edge.
module tb_hll_touch_dispatcher;

  logic         clk = 1'b0;
  logic         reset_n;
  logic         hash_valid;
  logic         hash_ready;
  logic [63:0]  hash_data;
  logic [15:0]  cell_active;
  logic         touch_valid;
  logic [3:0]   touch_cell;
  logic [255:0] touch_attempts;
  logic         busy;
  logic [15:0]  dropped_count;

  int checks = 0;
  int errors = 0;

  int          riseCyc[$];
  logic [3:0]  riseCell[$];
  logic [255:0] riseAtt[$];

  logic [63:0]  hv [6];
  logic [255:0] one256;
  logic         sawFull;

  hll_touch_dispatcher dut (
    .clk            (clk),
    .reset_n        (reset_n),
    .hash_valid     (hash_valid),
    .hash_ready     (hash_ready),
    .hash_data      (hash_data),
    .cell_active    (cell_active),
    .touch_valid    (touch_valid),
    .touch_cell     (touch_cell),
    .touch_attempts (touch_attempts),
    .busy           (busy),
    .dropped_count  (dropped_count)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic doReset();
    reset_n     = 1'b0;
    hash_valid  = 1'b0;
    hash_data   = '0;
    cell_active = '0;
    @(negedge clk);
    @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);
  endtask

  // Watch n falling edges; record every rising edge of touch_valid and
  // check the one-hot / qualified-by-valid invariant on touch_attempts.
  task automatic watchTouches(input int n);
    logic prev;
    prev = touch_valid;
    riseCyc.delete();
    riseCell.delete();
    riseAtt.delete();
    for (int c = 0; c < n; c++) begin
      @(negedge clk);
      chk("attempts_invariant",
          {255'd0, ($onehot0(touch_attempts) && (touch_attempts == '0 || touch_valid))},
          256'd1);
      if (touch_valid && !prev) begin
        riseCyc.push_back(c);
        riseCell.push_back(touch_cell);
        riseAtt.push_back(touch_attempts);
      end
      prev = touch_valid;
    end
  endtask

  initial begin
    one256 = 256'd1;
    hv[0] = 64'h101; hv[1] = 64'h212; hv[2] = 64'h323;
    hv[3] = 64'h434; hv[4] = 64'h545; hv[5] = 64'h656;

    // Reset state, sampled while reset is held
    reset_n     = 1'b0;
    hash_valid  = 1'b0;
    hash_data   = '0;
    cell_active = '0;
    @(negedge clk);
    @(negedge clk);
    chk("rst_touch_valid", {255'd0, touch_valid}, 256'd0);
    chk("rst_touch_cell", {252'd0, touch_cell}, 256'd0);
    chk("rst_touch_attempts", touch_attempts, 256'd0);
    chk("rst_dropped", {240'd0, dropped_count}, 256'd0);
    chk("rst_busy", {255'd0, busy}, 256'd0);
    reset_n = 1'b1;
    @(negedge clk);
    chk("rst_hash_ready", {255'd0, hash_ready}, 256'd1);
    chk("rst_busy_after", {255'd0, busy}, 256'd0);

    // Single touch: 0x253 -> cell 3, lane 37, valid for one cycle
    hash_data  = 64'h253;
    hash_valid = 1'b1;
    @(negedge clk);
    hash_valid = 1'b0;
    chk("t1_busy_queued", {255'd0, busy}, 256'd1);
    chk("t1_no_touch_E0", {255'd0, touch_valid}, 256'd0);
    @(negedge clk);
    chk("t1_no_touch_E1", {255'd0, touch_valid}, 256'd0);
    @(negedge clk);
    chk("t1_valid_E2", {255'd0, touch_valid}, 256'd1);
    chk("t1_cell_E2", {252'd0, touch_cell}, 256'd3);
    chk("t1_attempts_E2", touch_attempts, one256 << 37);
    @(negedge clk);
    chk("t1_valid_E3", {255'd0, touch_valid}, 256'd0);
    chk("t1_attempts_E3", touch_attempts, 256'd0);
    chk("t1_cell_hold", {252'd0, touch_cell}, 256'd3);
    chk("t1_busy_gap", {255'd0, busy}, 256'd1);
    @(negedge clk);
    chk("t1_idle_busy", {255'd0, busy}, 256'd0);
    chk("t1_dropped", {240'd0, dropped_count}, 256'd0);

    // Active cell suppresses the touch
    doReset();
    cell_active = 16'h0008;
    hash_data   = 64'h253;
    hash_valid  = 1'b1;
    @(negedge clk);
    hash_valid = 1'b0;
    watchTouches(8);
    chk("act_no_touch", 256'(riseCyc.size()), 256'd0);
    chk("act_dropped", {240'd0, dropped_count}, 256'd1);
    chk("act_idle", {255'd0, busy}, 256'd0);
    cell_active = '0;

    // Six back-to-back hashes through a depth-4 FIFO
    doReset();
    sawFull = 1'b0;
    fork
      begin
        for (int i = 0; i < 6; i++) begin
          int w;
          hash_data  = hv[i];
          hash_valid = 1'b1;
          w = 0;
          while (!hash_ready && w < 50) begin
            sawFull = 1'b1;
            @(negedge clk);
            w++;
          end
          if (w >= 50) chk("burst_push_timeout", 256'd1, 256'd0);
          @(negedge clk);
        end
        hash_valid = 1'b0;
      end
      watchTouches(40);
    join
    chk("burst_saw_full", {255'd0, sawFull}, 256'd1);
    chk("burst_count", 256'(riseCyc.size()), 256'd6);
    if (riseCyc.size() == 6) begin
      for (int i = 0; i < 6; i++) begin
        chk($sformatf("burst_cell_%0d", i), {252'd0, riseCell[i]}, 256'(i + 1));
        chk($sformatf("burst_att_%0d", i), riseAtt[i], one256 << (8'h10 + 8'h11 * i));
        if (i > 0) chk($sformatf("burst_space_%0d", i), 256'(riseCyc[i] - riseCyc[i-1]), 256'd4);
      end
    end
    chk("burst_dropped", {240'd0, dropped_count}, 256'd0);
    chk("burst_idle", {255'd0, busy}, 256'd0);

    // Duplicate hashes
    doReset();
    hash_data  = 64'h253;
    hash_valid = 1'b1;
    @(negedge clk);
    @(negedge clk);
    hash_valid = 1'b0;
    watchTouches(16);
`ifdef HLL_TOUCH_DEDUP_EN
    chk("dup_touches", 256'(riseCyc.size()), 256'd1);
    chk("dup_dropped", {240'd0, dropped_count}, 256'd1);
`else
    chk("dup_touches", 256'(riseCyc.size()), 256'd2);
    chk("dup_dropped", {240'd0, dropped_count}, 256'd0);
`endif

    // Reset during ISSUE with two hashes still queued
    doReset();
    for (int i = 0; i < 3; i++) begin
      hash_data  = hv[i];
      hash_valid = 1'b1;
      @(negedge clk);
    end
    hash_valid = 1'b0;
    chk("mid_in_issue", {255'd0, touch_valid}, 256'd1);
    reset_n = 1'b0;
    #1;
    chk("mid_valid_drop", {255'd0, touch_valid}, 256'd0);
    chk("mid_att_drop", touch_attempts, 256'd0);
    @(negedge clk);
    reset_n = 1'b1;
    watchTouches(12);
    chk("mid_no_touch", 256'(riseCyc.size()), 256'd0);
    chk("mid_busy", {255'd0, busy}, 256'd0);
    chk("mid_ready", {255'd0, hash_ready}, 256'd1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
